// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scanner with a prescaler, a frame-synchronous double buffer and dead time.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks the segments of leading zero digits above digit 0.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_CYCLES  = 0,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    we,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    frame_done
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = 5 * NUM_DIGITS;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};

  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         pend_q, pend_d, disp_q, disp_d;
  logic                  started_q, started_d;
  logic                  frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0] an_q, an_d, sel;
  logic [7:0]            seg_q, seg_d;
  logic                  tick, wrap, live, lz, dp_bit;
  logic [3:0]            nib;

  // Prescaler, slot index, buffers: the display buffer only changes on a frame wrap, taking the old pending value.
  always_comb begin
    tick         = pcnt_q == PMAX;
    wrap         = tick && idx_q == LAST;
    pcnt_d       = tick ? '0 : pcnt_q + 1'b1;
    idx_d        = tick ? (idx_q == LAST ? '0 : idx_q + 1'b1) : idx_q;
    pend_d       = we ? {dp_in, data_in} : pend_q;
    disp_d       = wrap ? pend_q : disp_q;
    started_d    = started_q | tick;
    frame_done_d = wrap;
  end

  // Output image for the slot being entered, using the buffer as it will be after this edge.
  always_comb begin
    nib    = disp_d[4*idx_d +: 4];
    dp_bit = disp_d[4*NUM_DIGITS + idx_d];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lz     = idx_d != '0 && (disp_d[4*NUM_DIGITS-1:0] >> (4*idx_d)) == '0;
`else
    lz     = 1'b0;
`endif
    sel    = NUM_DIGITS'(1) << idx_d;
    live   = ena && started_d;
    seg_d  = live ? {~dp_bit, lz ? 7'h7F : decode(nib)} : 8'hFF;
    an_d   = (live && int'(pcnt_d) >= BLANK_CYCLES) ? (AN_ACTIVE_LOW != 0 ? ~sel : sel) : AN_OFF;
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q       <= '0;
      idx_q        <= LAST;
      pend_q       <= '0;
      disp_q       <= '0;
      started_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= 8'hFF;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      started_q    <= started_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed and random scan checks against a cycle-count based reference model.
module tb_seg7_scan_ctrl;
  logic        clk = 0, rst = 0, ena = 0, we = 0;
  logic [15:0] data_in = 0;
  logic [3:0]  dp_in = 0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_done;
  int          errors = 0, checks = 0;
  int          k;
  logic [19:0] m_pend, m_disp;

  localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .AN_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .ena(ena), .we(we), .data_in(data_in), .dp_in(dp_in),
    .an(an), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic bit is_wrap(int n);
    return n > 0 && n % 8 == 0 && (n / 8 - 1) % 4 == 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic step(input logic w, input logic [15:0] d, input logic [3:0] p, input logic e);
    logic [7:0] es;
    logic [3:0] ea;
    int t, idx, pc;
    we = w; data_in = d; dp_in = p; ena = e;
    @(posedge clk);
    k++;
    if (is_wrap(k)) m_disp = m_pend;
    if (w) m_pend = {p, d};
    t = k / 8; pc = k % 8; idx = (t - 1) % 4;
    es = 8'hFF; ea = 4'hF;
    if (e && t > 0) begin
      es = {~m_disp[16 + idx], DEC[m_disp[4*idx +: 4]]};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (idx > 0 && (m_disp[15:0] >> (4 * idx)) == 0) es[6:0] = 7'h7F;
`endif
      ea = pc < 2 ? 4'hF : ~(4'b0001 << idx);
    end
    #1;
    chk("seg", seg, es);
    chk("an", an, ea);
    chk("frame_done", frame_done, is_wrap(k));
  endtask

  initial begin
    k = 0; m_pend = 0; m_disp = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_an", an, 4'hF);
    chk("reset_seg", seg, 8'hFF);
    chk("reset_fd", frame_done, 0);
    rst = 1;
    step(1, 16'h12AF, 4'h0, 1);
    repeat (6) step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("first_tick_seg", seg, 8'h8E);
    chk("first_tick_fd", frame_done, 1);
    chk("first_tick_an", an, 4'hF);
    repeat (2) step(0, 0, 0, 1);
    chk("first_anode", an, 4'b1110);
    repeat (8) step(0, 0, 0, 1);
    step(1, 16'h0003, 4'h0, 1);
    repeat (40) step(0, 0, 0, 1);
    while (!is_wrap(k + 1)) step(0, 0, 0, 1);
    step(1, 16'h4567, 4'b0100, 1);
    repeat (70) step(0, 0, 0, 1);
    step(1, 16'h0050, 4'h0, 1);
    repeat (40) step(0, 0, 0, 1);
    repeat (20) step(0, 0, 0, 0);
    repeat (20) step(0, 0, 0, 1);
    repeat (600) step($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom), $urandom_range(0, 9) != 0);
    while (!(k % 8 == 4 && k >= 8)) step(0, 0, 0, 1);
    #3;
    rst = 0;
    #1;
    chk("async_rst_an", an, 4'hF);
    chk("async_rst_seg", seg, 8'hFF);
    chk("async_rst_fd", frame_done, 0);
    @(posedge clk);
    #1;
    k = 0; m_pend = 0; m_disp = 0;
    rst = 1;
    repeat (200) step($urandom_range(0, 5) == 0, 16'($urandom), 4'($urandom), $urandom_range(0, 7) != 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
